// File: rtl/chan_decoder_if.sv
// rtl/chan_decoder_if.sv - request/beat handshake bundle for chan_decoder
interface chan_decoder_if #(
    parameter int IN_W    = 3,
    parameter int NUM_OUT = 8,
    parameter int DWELL_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic [1:0]         mode;
    logic [DWELL_W-1:0] dwell;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_OUT-1:0] out_data;
    logic               out_err;
    logic               busy;

    modport master (
        output in_valid, in_data, mode, dwell, out_ready,
        input  in_ready, out_valid, out_data, out_err, busy
    );

    modport slave (
        input  in_valid, in_data, mode, dwell, out_ready,
        output in_ready, out_valid, out_data, out_err, busy
    );
endinterface

// File: rtl/chan_decoder.sv
// rtl/chan_decoder.sv - registered one-hot/thermometer/sweep channel decoder
module chan_decoder #(
    parameter int IN_W    = 3,
    parameter int NUM_OUT = 8,
    parameter int DWELL_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    chan_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SWEEP_OUT, SWEEP_GAP} state_t;

    localparam logic [IN_W-1:0] LAST  = IN_W'(NUM_OUT - 1);
    localparam logic [IN_W:0]   LIMIT = (IN_W + 1)'(NUM_OUT);

    state_t             state, state_next;
    logic               valid_q, valid_next;
    logic [NUM_OUT-1:0] data_q, data_next;
    logic               err_q, err_next;
    logic               busy_q, busy_next;
    logic [IN_W-1:0]    idx_q, idx_next;
    logic [IN_W-1:0]    left_q, left_next;
    logic [DWELL_W-1:0] dwell_q, dwell_next;
    logic [DWELL_W-1:0] cnt_q, cnt_next;
    logic               ready;
    logic               range_err;
    logic [IN_W-1:0]    idx_inc;

    function automatic logic [NUM_OUT-1:0] onehot(input logic [IN_W-1:0] i);
        logic [NUM_OUT-1:0] v;
        for (int k = 0; k < NUM_OUT; k++) v[k] = (i == IN_W'(k));
        return v;
    endfunction

    function automatic logic [NUM_OUT-1:0] therm(input logic [IN_W-1:0] i);
        logic [NUM_OUT-1:0] v;
        for (int k = 0; k < NUM_OUT; k++) v[k] = (IN_W'(k) <= i);
        return v;
    endfunction

    assign range_err = ({1'b0, bus.in_data} >= LIMIT);
    // Sweep index wraps at NUM_OUT, not at the natural 2^IN_W boundary
    assign idx_inc   = (idx_q == LAST) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            left_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_next;
            valid_q <= valid_next;
            data_q  <= data_next;
            err_q   <= err_next;
            busy_q  <= busy_next;
            idx_q   <= idx_next;
            left_q  <= left_next;
            dwell_q <= dwell_next;
            cnt_q   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        valid_next = valid_q;
        data_next  = data_q;
        err_next   = err_q;
        busy_next  = busy_q;
        idx_next   = idx_q;
        left_next  = left_q;
        dwell_next = dwell_q;
        cnt_next   = cnt_q;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = !valid_q || bus.out_ready;
                if (bus.in_valid && ready) begin
                    valid_next = 1'b1;
                    err_next   = 1'b0;
                    if (range_err || bus.mode == 2'b11) begin
                        data_next = '0;
                        err_next  = 1'b1;
                    end else if (bus.mode == 2'b00) begin
                        data_next = onehot(bus.in_data);
                    end else if (bus.mode == 2'b01) begin
                        data_next = therm(bus.in_data);
                    end else begin
                        data_next  = onehot(bus.in_data);
                        busy_next  = 1'b1;
                        state_next = SWEEP_OUT;
                        idx_next   = bus.in_data;
                        left_next  = LAST;
                        dwell_next = bus.dwell;
                    end
                end else if (bus.out_ready) begin
                    valid_next = 1'b0;
                end
            end
            SWEEP_OUT: begin
                if (bus.out_ready) begin
                    if (left_q == '0) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        valid_next = 1'b0;
                    end else begin
                        idx_next  = idx_inc;
                        left_next = left_q - 1'b1;
                        if (dwell_q == '0) begin
                            data_next = onehot(idx_inc);
                        end else begin
                            state_next = SWEEP_GAP;
                            valid_next = 1'b0;
                            cnt_next   = dwell_q;
                        end
                    end
                end
            end
            SWEEP_GAP: begin
                // Count hits its last idle cycle: next beat goes valid on this edge
                if (cnt_q <= 1) begin
                    state_next = SWEEP_OUT;
                    valid_next = 1'b1;
                    data_next  = onehot(idx_q);
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_q - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_err   = err_q;
    assign bus.busy      = busy_q;
endmodule
